// File: rtl/dds_pkg.sv
// Shared types and widths for the DDS sweep sequencer and the sin_dds core.
package dds_pkg;

    localparam int DDS_PHASE_WIDTH = 32;
    localparam int DDS_STEP_WIDTH  = 16;
    localparam int DDS_DWELL_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Shadow copy of one sweep configuration, captured on a cfg handshake.
    typedef struct packed {
        logic [DDS_PHASE_WIDTH-1:0] f_start;
        logic [DDS_PHASE_WIDTH-1:0] f_step;
        logic [DDS_STEP_WIDTH-1:0]  n_steps;
        logic [DDS_DWELL_WIDTH-1:0] dwell;
        logic [DDS_PHASE_WIDTH-1:0] pha;
        logic                       cont;
    } sweep_cfg_t;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep (chirp) / fixed tone sequencer feeding sin_dds.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; config handshake accepted, fre_word held
// RUN   | stepping fre_word once every dwell period
// DONE  | single-shot sweep finished; done pulses for this one cycle
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = DDS_PHASE_WIDTH,
    parameter int STEP_WIDTH  = DDS_STEP_WIDTH,
    parameter int DWELL_WIDTH = DDS_DWELL_WIDTH
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_f_start,
    input  logic [PHASE_WIDTH-1:0] cfg_f_step,
    input  logic [STEP_WIDTH-1:0]  cfg_n_steps,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [PHASE_WIDTH-1:0] cfg_pha,
    input  logic                   cfg_cont,
    input  logic                   start,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] fre_word,
    output logic [PHASE_WIDTH-1:0] pha_word,
    output logic [STEP_WIDTH-1:0]  step_idx,
    output logic                   busy,
    output logic                   done
);

    sweep_state_t           state_q;
    sweep_cfg_t             cfg_q;
    logic [PHASE_WIDTH-1:0] fre_q;
    logic [STEP_WIDTH-1:0]  idx_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q;
    logic                   busy_q;
    logic                   done_q;

    sweep_cfg_t             cfg_in;
    sweep_cfg_t             cfg_d;
    logic                   cfg_xfer;
    logic [DWELL_WIDTH-1:0] dwell_last;
    logic [STEP_WIDTH-1:0]  step_last;
    logic                   point_end;

    assign cfg_ready = (state_q == IDLE);
    assign cfg_xfer  = cfg_valid && cfg_ready;

    // Pack the raw config inputs into the shadow layout.
    always_comb begin
        cfg_in         = '0;
        cfg_in.f_start = cfg_f_start;
        cfg_in.f_step  = cfg_f_step;
        cfg_in.n_steps = cfg_n_steps;
        cfg_in.dwell   = cfg_dwell;
        cfg_in.pha     = cfg_pha;
        cfg_in.cont    = cfg_cont;
    end

    // A config arriving together with start is the one the sweep uses.
    assign cfg_d = cfg_xfer ? cfg_in : cfg_q;

    // Zero dwell or zero steps behave as one; compare against the last value.
    assign dwell_last = (cfg_q.dwell == '0)   ? '0 : cfg_q.dwell - DWELL_WIDTH'(1);
    assign step_last  = (cfg_q.n_steps == '0) ? '0 : cfg_q.n_steps - STEP_WIDTH'(1);
    assign point_end  = (dwell_cnt_q == dwell_last);

    // Sweep FSM with dwell/step counters, shadow config and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            fre_q       <= '0;
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        fre_q       <= cfg_d.f_start;
                        idx_q       <= '0;
                        dwell_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        dwell_cnt_q <= '0;
                    end else if (point_end) begin
                        dwell_cnt_q <= '0;
                        if (idx_q != step_last) begin
                            fre_q <= fre_q + cfg_q.f_step;
                            idx_q <= idx_q + STEP_WIDTH'(1);
                        end else if (cfg_q.cont) begin
                            fre_q <= cfg_q.f_start;
                            idx_q <= '0;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + DWELL_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fre_word = fre_q;
    assign pha_word = cfg_q.pha;
    assign step_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: vector table plus hand sequences,
// expected per-cycle outputs flow through a scoreboard queue.
module tb_dds_sweep_ctrl;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_f_start = '0;
    logic [31:0] cfg_f_step = '0;
    logic [15:0] cfg_n_steps = '0;
    logic [23:0] cfg_dwell = '0;
    logic [31:0] cfg_pha = '0;
    logic        cfg_cont = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] fre_word;
    logic [31:0] pha_word;
    logic [15:0] step_idx;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    dds_sweep_ctrl dut (
        .clock      (clock),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_f_start(cfg_f_start),
        .cfg_f_step (cfg_f_step),
        .cfg_n_steps(cfg_n_steps),
        .cfg_dwell  (cfg_dwell),
        .cfg_pha    (cfg_pha),
        .cfg_cont   (cfg_cont),
        .start      (start),
        .abort      (abort),
        .fre_word   (fre_word),
        .pha_word   (pha_word),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [31:0] fre;
        logic [15:0] idx;
        logic        busy;
        logic        done;
        logic        ready;
        logic [31:0] pha;
    } exp_t;

    typedef struct {
        logic [31:0] f_start;
        logic [31:0] f_step;
        logic [15:0] n;
        logic [23:0] d;
        logic [31:0] pha;
        bit          same;
        logic [31:0] exp_last;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs c cycles after start was sampled (c = 1 is the first RUN cycle).
    function automatic exp_t model(input vec_t v, input bit cont, input int c);
        exp_t e;
        int   n;
        int   d;
        int   k;
        n = (v.n == 0) ? 1 : int'(v.n);
        d = (v.d == 0) ? 1 : int'(v.d);
        e.pha = v.pha;
        if (cont || c <= n * d) begin
            k       = ((c - 1) / d) % n;
            e.fre   = v.f_start + 32'(k) * v.f_step;
            e.idx   = 16'(k);
            e.busy  = 1'b1;
            e.done  = 1'b0;
            e.ready = 1'b0;
        end else begin
            e.fre   = v.f_start + 32'(n - 1) * v.f_step;
            e.idx   = 16'(n - 1);
            e.busy  = 1'b0;
            e.done  = (c == n * d + 1);
            e.ready = (c != n * d + 1);
        end
        return e;
    endfunction

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got fre 0x%08h expected an entry", tag, fre_word);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".fre"},   fre_word,  e.fre);
        chk({tag, ".idx"},   32'(step_idx), 32'(e.idx));
        chk({tag, ".busy"},  32'(busy),  32'(e.busy));
        chk({tag, ".done"},  32'(done),  32'(e.done));
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(e.ready));
        chk({tag, ".pha"},   pha_word,  e.pha);
    endtask

    task automatic drive_cfg(input vec_t v, input bit cont);
        cfg_f_start = v.f_start;
        cfg_f_step  = v.f_step;
        cfg_n_steps = v.n;
        cfg_dwell   = v.d;
        cfg_pha     = v.pha;
        cfg_cont    = cont;
    endtask

    task automatic load_cfg(input vec_t v, input bit cont, input string tag);
        drive_cfg(v, cont);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk({tag, ".pha_load"}, pha_word, v.pha);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int d;
        drive_cfg(v, 1'b0);
        if (!v.same) load_cfg(v, 1'b0, tag);
        n = (v.n == 0) ? 1 : int'(v.n);
        d = (v.d == 0) ? 1 : int'(v.d);
        cfg_valid = v.same;
        start     = 1'b1;
        for (int c = 1; c <= n * d + 2; c++) sb_q.push_back(model(v, 1'b0, c));
        for (int c = 1; c <= n * d + 2; c++) begin
            tick();
            if (c == 1) begin
                start     = 1'b0;
                cfg_valid = 1'b0;
            end
            sb_check($sformatf("%s.c%0d", tag, c));
        end
        chk({tag, ".final_tone"}, fre_word, v.exp_last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vecs[0] = '{32'h028F5C29, 32'h028F5C29, 16'd5, 24'd4, 32'h12345678, 1'b0, 32'h0CCCCCCD};
        vecs[1] = '{32'hFFFFFFF0, 32'h00000020, 16'd3, 24'd1, 32'h00001000, 1'b0, 32'h00000030};
        vecs[2] = '{32'h00000020, 32'hFFFFFFF0, 16'd3, 24'd1, 32'h00000000, 1'b0, 32'h00000000};
        vecs[3] = '{32'h11111111, 32'h00000001, 16'd0, 24'd0, 32'h80000000, 1'b1, 32'h11111111};
        vecs[4] = '{32'h40000000, 32'h00000100, 16'd1, 24'd3, 32'h00000055, 1'b0, 32'h40000000};

        // Reset state, both while held and after release.
        tick();
        tick();
        for (int r = 0; r < 2; r++) begin
            chk("rst.fre",   fre_word, 32'h0);
            chk("rst.pha",   pha_word, 32'h0);
            chk("rst.idx",   32'(step_idx), 32'h0);
            chk("rst.busy",  32'(busy), 32'h0);
            chk("rst.done",  32'(done), 32'h0);
            chk("rst.ready", 32'(cfg_ready), 32'h1);
            rst = 1'b0;
            tick();
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Continuous sweep: wraps to point 0 with no gap, then abort holds the tone.
        load_cfg(vecs[0], 1'b1, "cont");
        start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            sb_q.push_back(model(vecs[0], 1'b1, c));
            tick();
            start = 1'b0;
            sb_check($sformatf("cont.c%0d", c));
        end
        e = model(vecs[0], 1'b1, 45);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("cont_abort.fre",   fre_word, e.fre);
        chk("cont_abort.busy",  32'(busy), 32'h0);
        chk("cont_abort.done",  32'(done), 32'h0);
        chk("cont_abort.ready", 32'(cfg_ready), 32'h1);

        // Single shot aborted in the third point; config offered during RUN is refused.
        load_cfg(vecs[0], 1'b0, "abort");
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            sb_q.push_back(model(vecs[0], 1'b0, c));
            tick();
            start = 1'b0;
            if (c == 6) cfg_valid = 1'b0;
            sb_check($sformatf("abort.c%0d", c));
            if (c == 5) begin
                cfg_f_start = 32'hAAAAAAAA;
                cfg_pha     = 32'hDEADBEEF;
                cfg_valid   = 1'b1;
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.fre",   fre_word, 32'h07AE147B);
        chk("abort.busy",  32'(busy), 32'h0);
        chk("abort.ready", 32'(cfg_ready), 32'h1);
        chk("abort.pha",   pha_word, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            chk("abort.no_done", 32'(done), 32'h0);
            chk("abort.hold",    fre_word, 32'h07AE147B);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.fre",  fre_word, 32'h028F5C29);
        chk("restart.busy", 32'(busy), 32'h1);
        chk("restart.pha",  pha_word, 32'h12345678);

        // Reset in the middle of RUN clears everything; a fresh sweep then works.
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        chk("rst_run.fre",   fre_word, 32'h0);
        chk("rst_run.pha",   pha_word, 32'h0);
        chk("rst_run.idx",   32'(step_idx), 32'h0);
        chk("rst_run.busy",  32'(busy), 32'h0);
        chk("rst_run.done",  32'(done), 32'h0);
        chk("rst_run.ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        tick();
        run_vec(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
